// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control and status bundle for countdown_timer
interface countdown_timer_if #(
  parameter int WIDTH = 13
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             paused;
  logic             expired;
  logic             done;

  modport master (
    output load, load_value, start, pause, en,
    input  count, running, paused, expired, done
  );

  modport slave (
    input  load, load_value, start, pause, en,
    output count, running, paused, expired, done
  );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable prescaled down-counter with expiry flag; option COUNTDOWN_AUTO_RELOAD_EN
module countdown_timer #(
  parameter int WIDTH    = 13,
  parameter int TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] count_q;
  logic [PW-1:0]    presc;
  logic             done_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  // State, count and prescaler update; reset > load > pause > start, counting last
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      count_q <= '0;
      presc   <= '0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else if (bus.load) begin
      state   <= S_IDLE;
      count_q <= bus.load_value;
      presc   <= '0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= bus.load_value;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.pause) begin
        // prescaler is deliberately left alone so resume picks up mid-period
        if (state == S_RUN) state <= S_PAUSE;
      end else if (bus.start && state == S_IDLE) begin
        presc <= '0;
        if (count_q == '0) begin
          state  <= S_EXPIRED;
          done_q <= 1'b1;
        end else begin
          state <= S_RUN;
        end
      end else if (bus.start && state == S_PAUSE) begin
        state <= S_RUN;
      end else if (state == S_RUN && bus.en) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          if (count_q == WIDTH'(1)) begin
            done_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (reload_q != '0) begin
              count_q <= reload_q;
            end else begin
              count_q <= '0;
              state   <= S_EXPIRED;
            end
`else
            count_q <= '0;
            state   <= S_EXPIRED;
`endif
          end else begin
            count_q <= count_q - WIDTH'(1);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.running = (state == S_RUN);
  assign bus.paused  = (state == S_PAUSE);
  assign bus.done    = done_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign bus.expired = (state == S_EXPIRED) && (reload_q == '0);
`else
  assign bus.expired = (state == S_EXPIRED);
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - randomized model-checked bench for countdown_timer
module tb_countdown_timer;

  localparam int WIDTH = 13;
  localparam int TD    = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic clk;
  logic reset;
  countdown_timer_if #(.WIDTH(WIDTH)) bus ();

  countdown_timer #(.WIDTH(WIDTH), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: preset L, enabled running cycles accumulated since load, and mode.
  int L    = 0;
  int acc  = 0;
  int mode = M_IDLE;
  bit m_done = 1'b0;

  function automatic int m_count();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    if (L != 0) return L - ((acc / TD) % L);
`endif
    return L - (acc / TD);
  endfunction

  task automatic model_step();
    if (reset) begin
      L = 0; acc = 0; mode = M_IDLE; m_done = 1'b0;
    end else if (bus.load) begin
      L = int'(bus.load_value); acc = 0; mode = M_IDLE; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (bus.pause) begin
        if (mode == M_RUN) mode = M_PAUSE;
      end else if (bus.start && mode == M_IDLE) begin
        if (L == 0) begin
          mode = M_EXP; m_done = 1'b1;
        end else begin
          mode = M_RUN;
        end
      end else if (bus.start && mode == M_PAUSE) begin
        mode = M_RUN;
      end else if (mode == M_RUN && bus.en) begin
        acc++;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (L != 0) begin
          if (acc % (L * TD) == 0) m_done = 1'b1;
        end else
`endif
        if (acc == L * TD) begin
          mode = M_EXP; m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle after the first reset, outputs must match the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count",   int'(bus.count),   m_count());
      check("m_running", int'(bus.running), int'(mode == M_RUN));
      check("m_paused",  int'(bus.paused),  int'(mode == M_PAUSE));
      check("m_expired", int'(bus.expired), int'(mode == M_EXP));
      check("m_done",    int'(bus.done),    int'(m_done));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic step(input bit r, input bit l, input int lv, input bit s, input bit p, input bit e);
    reset = r; bus.load = l; bus.load_value = WIDTH'(lv);
    bus.start = s; bus.pause = p; bus.en = e;
    cyc();
  endtask

  task automatic idle(input int n, input bit e);
    repeat (n) step(1'b0, 1'b0, 0, 1'b0, 1'b0, e);
  endtask

  initial begin
    reset = 1'b0; bus.load = 1'b0; bus.load_value = '0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.en = 1'b0;
    @(negedge clk);

    // reset state
    step(1, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    check("rst_count", int'(bus.count), 0);
    check("rst_flags", int'({bus.running, bus.paused, bus.expired, bus.done}), 0);

    // load 3, start: decrements at 4, 8, 12 cycles after RUN entry
    step(0, 1, 3, 0, 0, 1);
    check("t1_load", int'(bus.count), 3);
    step(0, 0, 0, 1, 0, 1);
    check("t1_run", int'(bus.running), 1);
    idle(3, 1);
    check("t1_c3", int'(bus.count), 3);
    idle(1, 1);
    check("t1_c2", int'(bus.count), 2);
    idle(4, 1);
    check("t1_c1", int'(bus.count), 1);
    idle(4, 1);
    check("t1_done", int'(bus.done), 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("t1_reload", int'(bus.count), 3);
    check("t1_noexp", int'(bus.expired), 0);
`else
    check("t1_c0", int'(bus.count), 0);
    check("t1_exp", int'(bus.expired), 1);
    check("t1_norun", int'(bus.running), 0);
`endif
    idle(1, 1);
    check("t1_done_clr", int'(bus.done), 0);

    // pause holds prescaler; decrement 2 cycles after resume
    step(0, 1, 5, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    idle(6, 1);
    check("t2_c4", int'(bus.count), 4);
    repeat (10) step(0, 0, 0, 0, 1, 1);
    check("t2_paused", int'(bus.paused), 1);
    check("t2_hold", int'(bus.count), 4);
    step(0, 0, 0, 1, 0, 1);
    check("t2_resume", int'(bus.running), 1);
    idle(1, 1);
    check("t2_c4b", int'(bus.count), 4);
    idle(1, 1);
    check("t2_c3", int'(bus.count), 3);

    // load 0 then start: immediate expiry
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    check("t3_exp", int'(bus.expired), 1);
    check("t3_done", int'(bus.done), 1);
    check("t3_count", int'(bus.count), 0);
    idle(1, 1);
    check("t3_done1", int'(bus.done), 0);
    step(0, 0, 0, 1, 0, 1);
    check("t3_stay", int'({bus.running, bus.expired}), 1);

    // en low freezes mid-count
    step(0, 1, 2, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    idle(3, 1);
    idle(20, 0);
    check("t4_frozen", int'(bus.count), 2);
    idle(1, 1);
    check("t4_c1", int'(bus.count), 1);
    idle(3, 1);
    check("t4_c1b", int'(bus.count), 1);
    idle(1, 1);
    check("t4_done", int'(bus.done), 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("t4_reload", int'(bus.count), 2);
`else
    check("t4_c0", int'(bus.count), 0);
`endif

    // reset mid-run beats coincident load and start
    step(0, 1, 9, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    idle(8, 1);
    check("t5_c7", int'(bus.count), 7);
    step(1, 1, 5, 1, 0, 1);
    check("t5_count", int'(bus.count), 0);
    check("t5_flags", int'({bus.running, bus.paused, bus.expired, bus.done}), 0);
    idle(1, 1);
    check("t5_idle", int'({bus.running, bus.count}), 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // auto reload: 2,1,2,1 with done every 8 cycles
    step(0, 1, 2, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      idle(1, 1);
      check("t6_count", int'(bus.count), 2 - ((i / 4) % 2));
      check("t6_done", int'(bus.done), int'(i % 8 == 0));
      check("t6_noexp", int'(bus.expired), 0);
    end
`endif

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 12),
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 85);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter; the companion of the project's up-counter.
- The up-counter measures elapsed time. This block counts a preset down to zero and flags expiry.
- Used for game time limits and stimulus delays.
- Decrements on a prescaled tick derived from clk. Supports start, pause/resume and reload.

Parameters:
WIDTH, 13, bit width of the count value
TICK_DIV, 50000, clk cycles per decrement (≥2); sim benches use 4

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  capture load_value into count and reload register
load_value  input  WIDTH  preset value
start  input  1  begin or resume counting
pause  input  1  suspend counting
en  input  1  global enable; prescaler and count frozen while low
count  output  WIDTH  current remaining value
running  output  1  high in RUN
paused  output  1  high in PAUSE
expired  output  1  level, high in EXPIRED
done  output  1  one-cycle pulse on reaching zero

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- All outputs registered.
- Reset values: state=IDLE, count=0, reload register=0, prescaler=0, running=0, paused=0, expired=0, done=0.
- Reset mid-operation: returns to the reset values on the next edge regardless of other inputs.
- Per-edge priority: reset > load > pause > start.
- States:
  - IDLE: waiting to start.
  - RUN: counting down.
  - PAUSE: suspended.
  - EXPIRED: reached zero.
- load (any state): count<=load_value, reload<=load_value, prescaler<=0, state<=IDLE, done<=0.
- IDLE + start:
  - count!=0: go to RUN, prescaler<=0.
  - count==0: go to EXPIRED, done=1 the following cycle.
- RUN:
  - prescaler increments each cycle while en=1.
  - At prescaler==TICK_DIV-1 with en=1 (a tick): prescaler<=0 and count<=count-1.
  - Tick with count==1: count<=0, state<=EXPIRED, done<=1 on the same edge.
  - Decrement latency: first decrement occurs TICK_DIV enabled cycles after entering RUN.
- RUN + pause: go to PAUSE. Prescaler value is held, not cleared. Pause beats a coincident tick, so no decrement on that edge.
- PAUSE + start (pause=0): return to RUN and continue from the held prescaler value.
- EXPIRED: holds count=0. start is ignored. Only load or reset exits.
- en=0: prescaler and count frozen in every state. State transitions from start/pause/load still occur.
- done: high for exactly one cycle per expiry, then cleared.
- Wrap-around: count never decrements below 0. No underflow possible.
- running, paused and expired are decodes of the registered state and are mutually exclusive.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: a tick with count==1 sets count<=reload, stays in RUN, pulses done, and never enters EXPIRED.
  - If reload==0, behaviour is as when undefined.
  - expired is tied 0 whenever reload!=0.
- Undefined: expiry behaviour exactly as in Behaviour. No reload register is needed beyond what load captures.

Test Plan:
- TICK_DIV=4: reset, load_value=3 with load, start, en=1 held -> count 3→2→1→0 at 4, 8 and 12 cycles after RUN entry; done high one cycle together with count=0; expired=1 afterward; running=0.
- Load 5, start, pause after 6 cycles (count=4, prescaler=2), hold pause 10 cycles, then start -> count stays 4 while paused; next decrement occurs 2 cycles after resume.
- Load 0, start -> EXPIRED next cycle, done pulses once, count stays 0, running never asserts.
- Load 2, start, drop en for 20 cycles mid-count -> count and prescaler frozen; counting resumes where it left off; total expiry at 8 enabled cycles.
- Assert reset while RUN with count=7 -> next cycle count=0, all flags 0, state IDLE; load and start together with reset have no effect.
- With COUNTDOWN_AUTO_RELOAD_EN: load 2, start, run 20 cycles -> count sequence 2,1,2,1,...; done pulses every 8 cycles; expired stays 0.
